// File: rtl/stream_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// stream_burst_ctrl_if
// AXI4-Stream style handshake bundle between the burst controller (master)
// and the downstream DMA / data mux (slave).
//   dst_valid  master->slave  M_AXIS_TVALID
//   dst_ready  slave->master  M_AXIS_TREADY
//   dst_last   master->slave  M_AXIS_TLAST
//   stream_i   master->slave  index of the beat currently presented
//   stream_v   master->slave  beat-fire strobe (valid & ready)
// -----------------------------------------------------------------------------
interface stream_burst_ctrl_if #(
    parameter int IDX_W = 5
);
    logic             dst_valid;
    logic             dst_ready;
    logic             dst_last;
    logic [IDX_W-1:0] stream_i;
    logic             stream_v;

    modport master (
        output dst_valid,
        output dst_last,
        output stream_i,
        output stream_v,
        input  dst_ready
    );

    modport slave (
        input  dst_valid,
        input  dst_last,
        input  stream_i,
        input  stream_v,
        output dst_ready
    );
endinterface

// File: rtl/stream_burst_ctrl.sv
// -----------------------------------------------------------------------------
// stream_burst_ctrl
// Output-stream controller for the accelerator result path. Every `last` pulse
// requests one burst of BEATS beats, eligible DELAY cycles later. Requests that
// arrive while a burst is running are queued (up to PEND_DEPTH) and run
// back-to-back without a bubble. TVALID/TLAST/index are registered and held
// stable while the sink applies backpressure.
// Ports:
//   clk      single clock, rising edge
//   rst_n    synchronous reset, active low
//   last     one-cycle burst request from the instruction decoder
//   m_axis   handshake bundle (master side): dst_valid, dst_ready, dst_last,
//            stream_i, stream_v
//   busy     streaming, or any request queued / still in the delay line
//   pending  queued bursts not yet started (active burst excluded)
//   err_ovf  sticky: a request was dropped because the queue was full
// -----------------------------------------------------------------------------
module stream_burst_ctrl #(
    parameter int BEATS      = 32,
    parameter int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
    parameter int DELAY      = 2,
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = $clog2(PEND_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                last,
    stream_burst_ctrl_if.master m_axis,
    output logic                busy,
    output logic [CNT_W-1:0]    pending,
    output logic                err_ovf
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] PEND_MAX     = CNT_W'(PEND_DEPTH);
    // Single-beat bursts present TLAST on the very first beat.
    localparam logic             LAST_AT_ZERO = (BEATS == 1);

    state_t           state_q;
    logic             valid_q;
    logic             dlast_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] pend_q;
    logic             err_q;

    logic [CNT_W-1:0] pend_d;
    logic             err_d;
    logic [IDX_W-1:0] idx_inc;

    logic             dly_out;
    logic             dly_any;
    logic             req;
    logic             fire;
    logic             at_end;
    logic             start;
    logic             inc;
    logic             dec;

    // -------------------------------------------------------------------------
    // Settle window: a plain shift register on `last`; its tail is the point
    // where a request becomes eligible to start a burst.
    // -------------------------------------------------------------------------
    generate
        if (DELAY > 0) begin : g_dly
            logic [DELAY-1:0] dly_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= DELAY'({dly_q, last});
                end
            end

            assign dly_out = dly_q[DELAY-1];
            assign dly_any = |dly_q;
        end else begin : g_nodly
            assign dly_out = last;
            assign dly_any = 1'b0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Start / queue accounting
    // -------------------------------------------------------------------------
    always_comb begin
        req     = dly_out | (pend_q != '0);
        fire    = valid_q & m_axis.dst_ready;
        at_end  = fire & (idx_q == LAST_IDX);
        idx_inc = idx_q + IDX_W'(1);
        // A start is either a launch from IDLE or a no-bubble restart when the
        // final beat of the running burst fires.
        start   = req & ((state_q == IDLE) | at_end);
        // A fresh request that is not consumed by a start this cycle is queued;
        // a start that had no fresh request consumes a queued one.
        inc     = dly_out & ~start;
        dec     = start & ~dly_out;

        pend_d  = pend_q;
        err_d   = err_q;
        if (inc) begin
            if (pend_q == PEND_MAX) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (dec) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Burst FSM with registered handshake outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dlast_q <= 1'b0;
            idx_q   <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        dlast_q <= LAST_AT_ZERO;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    // Without a fire everything holds, keeping TVALID/TLAST/
                    // index stable under backpressure.
                    if (fire) begin
                        if (!at_end) begin
                            idx_q   <= idx_inc;
                            dlast_q <= (idx_inc == LAST_IDX);
                        end else if (start) begin
                            idx_q   <= '0;
                            dlast_q <= LAST_AT_ZERO;
                        end else begin
                            valid_q <= 1'b0;
                            dlast_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign m_axis.dst_valid = valid_q;
    assign m_axis.dst_last  = dlast_q;
    assign m_axis.stream_i  = idx_q;
    assign m_axis.stream_v  = fire;

    assign busy    = (state_q == STREAM) | (pend_q != '0) | dly_any | last;
    assign pending = pend_q;
    assign err_ovf = err_q;

endmodule

// File: tb/tb_stream_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stream_burst_ctrl
// Three controller instances with different parameter sets run side by side:
//   d0: BEATS=32 DELAY=2 PEND_DEPTH=4 (defaults)
//   d1: BEATS=4  DELAY=2 PEND_DEPTH=2 (queue overflow)
//   d2: BEATS=1  DELAY=0 PEND_DEPTH=4 (degenerate burst / zero delay)
// A request-level reference model tracks every instance; outputs are compared
// each cycle on the falling edge, followed by directed scenarios and random
// traffic.
// -----------------------------------------------------------------------------
module tb_stream_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lst;
    logic [2:0] rdy;
    int         cyc = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_burst_ctrl_if #(.IDX_W(5)) ax0 ();
    stream_burst_ctrl_if #(.IDX_W(2)) ax1 ();
    stream_burst_ctrl_if #(.IDX_W(1)) ax2 ();

    assign ax0.dst_ready = rdy[0];
    assign ax1.dst_ready = rdy[1];
    assign ax2.dst_ready = rdy[2];

    logic       busy0, busy1, busy2;
    logic       err0, err1, err2;
    logic [2:0] pend0;
    logic [1:0] pend1;
    logic [2:0] pend2;

    stream_burst_ctrl #(.BEATS(32), .DELAY(2), .PEND_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .last(lst[0]), .m_axis(ax0.master),
        .busy(busy0), .pending(pend0), .err_ovf(err0)
    );

    stream_burst_ctrl #(.BEATS(4), .DELAY(2), .PEND_DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .last(lst[1]), .m_axis(ax1.master),
        .busy(busy1), .pending(pend1), .err_ovf(err1)
    );

    stream_burst_ctrl #(.BEATS(1), .DELAY(0), .PEND_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .last(lst[2]), .m_axis(ax2.master),
        .busy(busy2), .pending(pend2), .err_ovf(err2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: request history, a queue count and the active burst.
    // ---------------------------------------------------------------------
    bit m_act  [3];
    int m_beat [3];
    int m_pend [3];
    bit m_err  [3];
    bit hist   [3][8];   // hist[d][k] = `last` sampled k+1 edges ago

    task automatic model_step(input int d, input int beats, input int dly,
                              input int depth, input logic l, input logic r,
                              input logic rn);
        bit elig, fire, done, start;
        if (!rn) begin
            m_act[d]  = 1'b0;
            m_beat[d] = 0;
            m_pend[d] = 0;
            m_err[d]  = 1'b0;
            for (int k = 0; k < 8; k++) hist[d][k] = 1'b0;
        end else begin
            elig = (dly == 0) ? l : hist[d][dly-1];
            for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = l;
            fire  = m_act[d] && r;
            done  = !m_act[d] || (fire && m_beat[d] == beats - 1);
            start = done && (elig || m_pend[d] > 0);
            if (fire && m_beat[d] < beats - 1) begin
                m_beat[d]++;
            end else if (start) begin
                m_act[d]  = 1'b1;
                m_beat[d] = 0;
                if (!elig) m_pend[d]--;
            end else if (done) begin
                m_act[d] = 1'b0;
            end
            if (elig && !start) begin
                if (m_pend[d] == depth) m_err[d] = 1'b1;
                else                    m_pend[d]++;
            end
        end
    endtask

    task automatic check_dut(input int d, input int beats, input int dly,
                             input logic v, input logic l, input int idx,
                             input logic sv, input logic bz, input int pend,
                             input logic er, input logic li, input logic ri);
        logic hs;
        hs = li;
        for (int k = 0; k < dly; k++) hs |= hist[d][k];
        hs |= m_act[d] | (m_pend[d] > 0);
        check_eq($sformatf("d%0d.valid", d), int'(v), int'(m_act[d]));
        check_eq($sformatf("d%0d.last", d), int'(l),
                 int'(m_act[d] && m_beat[d] == beats - 1));
        if (m_act[d]) check_eq($sformatf("d%0d.idx", d), idx, m_beat[d]);
        check_eq($sformatf("d%0d.stream_v", d), int'(sv), int'(m_act[d] && ri));
        check_eq($sformatf("d%0d.busy", d), int'(bz), int'(hs));
        check_eq($sformatf("d%0d.pending", d), pend, m_pend[d]);
        check_eq($sformatf("d%0d.err_ovf", d), int'(er), int'(m_err[d]));
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, 32, 2, 4, lst[0], rdy[0], rst_n);
        model_step(1, 4,  2, 2, lst[1], rdy[1], rst_n);
        model_step(2, 1,  0, 4, lst[2], rdy[2], rst_n);
    end

    int fires [3];
    int lastc [3];

    always @(negedge clk) begin
        if (cyc > 0) begin
            check_dut(0, 32, 2, ax0.dst_valid, ax0.dst_last, int'(ax0.stream_i),
                      ax0.stream_v, busy0, int'(pend0), err0, lst[0], rdy[0]);
            check_dut(1, 4, 2, ax1.dst_valid, ax1.dst_last, int'(ax1.stream_i),
                      ax1.stream_v, busy1, int'(pend1), err1, lst[1], rdy[1]);
            check_dut(2, 1, 0, ax2.dst_valid, ax2.dst_last, int'(ax2.stream_i),
                      ax2.stream_v, busy2, int'(pend2), err2, lst[2], rdy[2]);
            if (ax0.stream_v) fires[0]++;
            if (ax1.stream_v) fires[1]++;
            if (ax2.stream_v) fires[2]++;
            if (ax0.stream_v && ax0.dst_last) lastc[0]++;
            if (ax1.stream_v && ax1.dst_last) lastc[1]++;
            if (ax2.stream_v && ax2.dst_last) lastc[2]++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] m);
        lst = m;
        step();
        lst = 3'b000;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!(busy0 | busy1 | busy2)) break;
            step();
        end
        check_eq(tag, int'(busy0 | busy1 | busy2), 0);
    endtask

    int f0, f1, f2, l0, l2;
    int lat0, lat2, run, maxrun, maxp;

    task automatic snap();
        f0 = fires[0]; f1 = fires[1]; f2 = fires[2];
        l0 = lastc[0]; l2 = lastc[2];
    endtask

    initial begin
        rst_n = 1'b0;
        lst   = 3'b000;
        rdy   = 3'b111;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single burst on all instances, sink always ready.
        snap();
        lat0 = -1;
        lat2 = -1;
        lst  = 3'b111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ax0.dst_valid && lat0 < 0) lat0 = k;
            if (ax2.dst_valid && lat2 < 0) lat2 = k;
            step();
            lst = 3'b000;
        end
        check_eq("latency_d0", lat0, 3);
        check_eq("latency_d2", lat2, 1);
        wait_idle("idle_single", 100);
        check_eq("single_fires_d0", fires[0] - f0, 32);
        check_eq("single_tlast_d0", lastc[0] - l0, 1);
        check_eq("single_fires_d1", fires[1] - f1, 4);
        check_eq("single_fires_d2", fires[2] - f2, 1);
        check_eq("single_tlast_d2", lastc[2] - l2, 1);

        // Backpressure: stall d0 for 5 cycles while beat 7 is presented.
        snap();
        pulse(3'b001);
        repeat (9) step();
        rdy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("stall_idx", int'(ax0.stream_i), 7);
            check_eq("stall_valid", int'(ax0.dst_valid), 1);
            step();
        end
        rdy[0] = 1'b1;
        wait_idle("idle_stall", 100);
        check_eq("stall_fires", fires[0] - f0, 32);
        check_eq("stall_tlast", lastc[0] - l0, 1);

        // Two requests 3 cycles apart: one continuous 64-beat TVALID run.
        snap();
        run    = 0;
        maxrun = 0;
        maxp   = 0;
        for (int k = 0; k < 120; k++) begin
            lst[0] = (k == 0 || k == 3);
            @(negedge clk);
            run = ax0.dst_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (int'(pend0) > maxp) maxp = int'(pend0);
            step();
        end
        lst = 3'b000;
        check_eq("b2b_run", maxrun, 64);
        check_eq("b2b_max_pending", maxp, 1);
        check_eq("b2b_fires", fires[0] - f0, 64);
        check_eq("b2b_tlast", lastc[0] - l0, 2);

        // Six requests with the sink stalled: queues saturate, overflow flags.
        snap();
        rdy = 3'b000;
        for (int k = 0; k < 12; k++) begin
            lst = (k % 2 == 0) ? 3'b111 : 3'b000;
            step();
        end
        lst = 3'b000;
        repeat (4) step();
        @(negedge clk);
        check_eq("ovf_pending_d1", int'(pend1), 2);
        check_eq("ovf_err_d1", int'(err1), 1);
        check_eq("ovf_pending_d0", int'(pend0), 4);
        rdy = 3'b111;
        step();
        wait_idle("idle_ovf", 400);
        check_eq("ovf_fires_d1", fires[1] - f1, 12);
        check_eq("ovf_fires_d0", fires[0] - f0, 160);
        check_eq("ovf_fires_d2", fires[2] - f2, 5);

        // Reset in the middle of a stalled burst.
        pulse(3'b001);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ax0.dst_valid && ax0.stream_i == 5'd10) break;
            step();
        end
        check_eq("reach_beat10", int'(ax0.stream_i), 10);
        rdy[0] = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", int'(ax0.dst_valid), 0);
        check_eq("rst_last", int'(ax0.dst_last), 0);
        check_eq("rst_pending", int'(pend0), 0);
        check_eq("rst_err", int'(err0), 0);
        rdy[0] = 1'b1;
        step();
        snap();
        pulse(3'b001);
        wait_idle("idle_after_rst", 100);
        check_eq("post_rst_fires", fires[0] - f0, 32);
        check_eq("post_rst_tlast", lastc[0] - l0, 1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 3; d++) begin
                lst[d] = !lst[d] && ($urandom_range(0, (d == 1) ? 5 : 25) == 0);
                rdy[d] = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n = 1'b1;
        lst   = 3'b000;
        rdy   = 3'b111;
        wait_idle("idle_random", 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_burst_ctrl.md
# stream_burst_ctrl

Parametrised output-stream controller for the accelerator's result path, driving the AXI4-Stream master handshake (M_AXIS_TVALID/TLAST) toward the DMA. Each `last` pulse from the instruction decoder schedules one burst of `BEATS` beats after a `DELAY`-cycle settle window, so in-flight store instructions on other cores complete first. Unlike the previous generation, it queues up to `PEND_DEPTH` bursts, runs them back-to-back, and holds TVALID stable under backpressure per AXI rules. The external data mux selects TDATA combinationally from `stream_i`.

## Interface
- `BEATS`, 32: beats per burst; ≥1.
- `IDX_W`, $clog2(BEATS) (min 1): width of `stream_i`.
- `DELAY`, 2: settle cycles between `last` and burst eligibility; 0 allowed.
- `PEND_DEPTH`, 4: max queued bursts not yet started; ≥1.
- `CNT_W`, $clog2(PEND_DEPTH+1): width of `pending`.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `last`  in  1  one-cycle pulse: final instruction issued; requests one burst.
- `dst_ready`  in  1  M_AXIS_TREADY.
- `dst_valid`  out  1  M_AXIS_TVALID, registered.
- `dst_last`  out  1  M_AXIS_TLAST, registered.
- `stream_i`  out  IDX_W  index of beat currently presented, registered.
- `stream_v`  out  1  beat-fire strobe, `dst_valid & dst_ready` (combinational).
- `busy`  out  1  high in STREAM or when any burst is pending/in the delay line.
- `pending`  out  CNT_W  queued bursts (excludes the active one).
- `err_ovf`  out  1  sticky: a request was dropped because the queue was full.

## Operation
- Delay line: `DELAY`-stage shift register on `last`; `dly_out` is its tail (`DELAY`=0: `dly_out = last`).
- `req = dly_out | (pending != 0)`.
- States: IDLE, STREAM.
  - IDLE: `dst_valid`=0. If `req`: `dst_valid`<=1, `stream_i`<=0, `dst_last`<=(BEATS==1), go STREAM.
  - STREAM: `dst_valid`=1 and `stream_i`/`dst_last` frozen while `dst_ready`=0. On fire with `stream_i`<BEATS-1: `stream_i`+1; `dst_last`<=(`stream_i`+1==BEATS-1).
  - On fire with `stream_i`==BEATS-1: if `req`, restart at index 0 with no bubble and stay STREAM; else `dst_valid`<=0, `dst_last`<=0, go IDLE.
- Start consumption: a start (IDLE launch or back-to-back restart) consumes `dly_out` if high, otherwise decrements `pending`.
- Queue update: `inc = dly_out & ~(start consumed dly_out)`; `dec = start & ~dly_out`. `pending` += inc − dec. If inc with `pending`==PEND_DEPTH and no dec: request dropped, `err_ovf`<=1 (cleared only by reset).
- `busy = (state==STREAM) | (pending!=0) | any delay-line stage set | last`.
- Data-path contract: TDATA = f(`stream_i`) combinationally; `stream_v` advances any data-side state.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; `dst_valid`, `dst_last`, `stream_i`, `pending`, `err_ovf`, delay line all 0; `stream_v`=0. Reset mid-burst aborts immediately: TVALID drops the next cycle, no TLAST.
- Latency: `last` high in cycle c → `dst_valid` first high in cycle c+DELAY+1 (default: c+3), regardless of `dst_ready`.
- Unstalled burst: exactly BEATS consecutive fires; `dst_last` high only on the fire with `stream_i`==BEATS-1.
- Back-to-back bursts: TVALID stays high; index wraps BEATS-1 → 0 in the next cycle.
- `dst_ready` low: outputs hold and no state advances, except the delay line and `pending` accounting, which keep running.
- `dst_last` is never high while `dst_valid` is low.

## Test plan
- Default params, `dst_ready`=1, `last` pulse at cycle 10 → `dst_valid` rises at cycle 13; `stream_i` 0..31 over cycles 13–44; `dst_last` only at 44; `busy` low from 45.
- Same, `dst_ready` low at cycles 20–24 → `stream_i`=7 and `dst_valid`=1 held through 24; beat 31 fires at cycle 49; 32 total `stream_v` strobes.
- Two `last` pulses 3 cycles apart → `pending`=1 during the first burst; 64 consecutive fires; single-cycle index wrap 31→0; `dst_last` exactly twice.
- PEND_DEPTH=2, six `last` pulses while `dst_ready`=0 → `pending` saturates at 2; `err_ovf`=1; after release, 3 bursts (active + 2) complete.
- DELAY=0, BEATS=1: `last` at cycle 5 → `dst_valid` and `dst_last` both high at cycle 6, low at 7.
- `rst_n`=0 at beat 10 of a stalled burst → next cycle all outputs 0 and `pending`=0; a new `last` after reset yields a normal burst.
